// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings for the decode/issue stage: exception codes, mult/div start codes, held-slot layout.
// No logic lives here; tnew/tuse widths stay with the parametrised modules.
package issue_scoreboard_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_RI   = 5'd10;

  typedef enum logic [1:0] {
    XS_NONE = 2'b00,
    XS_MUL  = 2'b01,
    XS_DIV  = 2'b10,
    XS_RSVD = 2'b11
  } xstart_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
  } held_t;

endpackage

// File: rtl/issue_scoreboard_tnew_scoreboard.sv
// Per-register tnew countdown: decrements on advance, one write port, two read ports, reg 0 never held.
// Latency 1 on writes, reads combinational; frozen whenever advance is low.
module tnew_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int TW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [TW-1:0] wr_val,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [TW-1:0] rd0,
  output logic [TW-1:0] rd1
);

  localparam logic [TW-1:0] ONE = 1;

  logic [TW-1:0] cnt [NREG];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (clear) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        if (advance && cnt[r] != '0) cnt[r] <= cnt[r] - ONE;
      // a fresh producer overrides that entry's decrement in the same cycle
      if (wr_en && wr_addr != '0) cnt[wr_addr] <= wr_val;
    end
  end

  assign rd0 = cnt[ra0];
  assign rd1 = cnt[ra1];

endmodule

// File: rtl/issue_scoreboard.sv
// Decode/issue stage: hazard check against tnew scoreboard and mult/div timer, one-entry output register.
// Latency 1 from fire to out_valid; holds and freezes the scoreboard while out_ready is low.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int TW      = 4,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  input  logic [AW-1:0] in_rs,
  input  logic [TW-1:0] in_rsuse,
  input  logic [AW-1:0] in_rt,
  input  logic [TW-1:0] in_rtuse,
  input  logic [AW-1:0] in_tar,
  input  logic [TW-1:0] in_tnew,
  input  logic          in_xalu,
  input  logic [1:0]    in_xstart,
  input  logic          in_ri,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [AW-1:0] out_tar,
  output logic [TW-1:0] out_tnew,
  output logic [4:0]    out_exc,
  output logic          xalu_busy,
  output logic [31:0]   stall_cnt
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int BW      = $clog2(MAX_LAT + 1);

  localparam logic [TW-1:0] TUSE_NONE = '1;
  localparam logic [BW-1:0] MUL_LOAD  = BW'(MUL_LAT);
  localparam logic [BW-1:0] DIV_LOAD  = BW'(DIV_LAT);
  localparam logic [BW-1:0] BUSY_ONE  = 1;

  held_t         held;
  logic [AW-1:0] held_tar;
  logic [TW-1:0] held_tnew;
  logic [BW-1:0] busy;
  logic [TW-1:0] rs_cnt, rt_cnt;
  logic          rs_haz, rt_haz, x_haz, hazard;
  logic          slot_free, fire, sb_wr;

  tnew_scoreboard #(.NREG(NREG), .AW(AW), .TW(TW)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .advance (out_ready),
    .clear   (flush),
    .wr_en   (sb_wr),
    .wr_addr (in_tar),
    .wr_val  (in_tnew),
    .ra0     (in_rs),
    .ra1     (in_rt),
    .rd0     (rs_cnt),
    .rd1     (rt_cnt)
  );

  // a source stalls only if its producer is still further away than the point it is consumed
  assign rs_haz    = (in_rsuse != TUSE_NONE) && (in_rs != '0) && (rs_cnt > in_rsuse);
  assign rt_haz    = (in_rtuse != TUSE_NONE) && (in_rt != '0) && (rt_cnt > in_rtuse);
  assign x_haz     = in_xalu && (busy != '0);
  assign hazard    = rs_haz || rt_haz || x_haz;

  assign slot_free = !held.valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush;
  assign fire      = in_valid && in_ready;
  assign sb_wr     = fire && !in_ri && (in_tnew != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      held      <= '0;
      held_tar  <= '0;
      held_tnew <= '0;
    end else if (flush) begin
      held.valid <= 1'b0;
    end else if (fire) begin
      held.valid <= 1'b1;
      held.pc    <= in_pc;
      if (in_ri) begin
        held.instr <= '0;
        held.exc   <= EXC_RI;
        held_tar   <= '0;
        held_tnew  <= '0;
      end else begin
        held.instr <= in_instr;
        held.exc   <= EXC_NONE;
        held_tar   <= in_tar;
        held_tnew  <= in_tnew;
      end
    end else if (out_ready) begin
      held.valid <= 1'b0;
    end
  end

  // mult/div timer runs regardless of downstream backpressure or flush
  always_ff @(posedge clk) begin
    if (!reset)
      busy <= '0;
    else if (fire && !in_ri && in_xstart == XS_MUL)
      busy <= MUL_LOAD;
    else if (fire && !in_ri && in_xstart == XS_DIV)
      busy <= DIV_LOAD;
    else if (busy != '0)
      busy <= busy - BUSY_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt <= '0;
    else if (in_valid && hazard && !flush && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign out_valid = held.valid;
  assign out_instr = held.instr;
  assign out_pc    = held.pc;
  assign out_exc   = held.exc;
  assign out_tar   = held_tar;
  assign out_tnew  = held_tnew;
  assign xalu_busy = (busy != '0);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus randomized traffic against a cycle-level model.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  in_rs, in_rt, in_tar;
  logic [3:0]  in_rsuse, in_rtuse, in_tnew;
  logic        in_xalu;
  logic [1:0]  in_xstart;
  logic        in_ri;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr, out_pc;
  logic [4:0]  out_tar;
  logic [3:0]  out_tnew;
  logic [4:0]  out_exc;
  logic        xalu_busy;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // reference state: pending result distance per register, mult/div cycles left, held slot
  int          m_cnt [32];
  int          m_busy;
  longint      m_stall;
  bit          m_ov;
  logic [31:0] m_instr, m_pc;
  int          m_tar, m_tnew, m_exc;

  issue_scoreboard dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs(in_rs), .in_rsuse(in_rsuse),
    .in_rt(in_rt), .in_rtuse(in_rtuse), .in_tar(in_tar), .in_tnew(in_tnew),
    .in_xalu(in_xalu), .in_xstart(in_xstart), .in_ri(in_ri), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_tar(out_tar), .out_tnew(out_tnew), .out_exc(out_exc),
    .xalu_busy(xalu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_hazard();
    bit h = 0;
    if (in_rsuse != 4'hF && in_rs != 0 && m_cnt[in_rs] > int'(in_rsuse)) h = 1;
    if (in_rtuse != 4'hF && in_rt != 0 && m_cnt[in_rt] > int'(in_rtuse)) h = 1;
    if (in_xalu && m_busy > 0) h = 1;
    return h;
  endfunction

  function automatic bit m_ready();
    return (!m_ov || out_ready) && !m_hazard() && !flush;
  endfunction

  // advance the model with the current inputs, then let the DUT take the same edge
  task automatic tick();
    bit fire, hz;
    hz   = m_hazard();
    fire = in_valid && m_ready();
    if (!reset) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_busy = 0; m_stall = 0; m_ov = 0;
      m_instr = 0; m_pc = 0; m_tar = 0; m_tnew = 0; m_exc = 0;
    end else begin
      if (in_valid && hz && !flush && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (fire && !in_ri && in_xstart == 2'b01)      m_busy = 5;
      else if (fire && !in_ri && in_xstart == 2'b10) m_busy = 10;
      else if (m_busy > 0)                           m_busy--;
      if (flush) begin
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_ov = 0;
      end else begin
        if (out_ready) foreach (m_cnt[r]) if (m_cnt[r] > 0) m_cnt[r]--;
        if (fire && !in_ri && in_tar != 0 && in_tnew != 0) m_cnt[in_tar] = in_tnew;
        if (fire) begin
          m_ov = 1; m_pc = in_pc;
          if (in_ri) begin
            m_instr = 0; m_tar = 0; m_tnew = 0; m_exc = 10;
          end else begin
            m_instr = in_instr; m_tar = in_tar; m_tnew = in_tnew; m_exc = 0;
          end
        end else if (out_ready) begin
          m_ov = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [3:0] rsuse,
                       input logic [4:0] rt, input logic [3:0] rtuse,
                       input logic [4:0] tar, input logic [3:0] tnew,
                       input logic xalu, input logic [1:0] xstart, input logic ri,
                       input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1; in_rs = rs; in_rsuse = rsuse; in_rt = rt; in_rtuse = rtuse;
    in_tar = tar; in_tnew = tnew; in_xalu = xalu; in_xstart = xstart; in_ri = ri;
    in_instr = instr; in_pc = pc;
  endtask

  task automatic do_reset();
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    // reset must win over a simultaneous flush and a would-be fire
    issue(0, 4'hF, 0, 4'hF, 5'd7, 4'd2, 0, 2'b01, 0, 32'hDEAD_BEEF, 32'h40);
    reset = 0; flush = 1; out_ready = 1;
    tick();
    reset = 1; flush = 0; in_valid = 0;
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_instr !== 32'd0 || out_pc !== 32'd0) begin errors++; $display("FAIL reset_instr_pc got=%h/%h want=0/0", out_instr, out_pc); end
    checks++; if ({out_tar, out_tnew, out_exc} !== 14'd0) begin errors++; $display("FAIL reset_tar_tnew_exc got=%0d/%0d/%0d want=0/0/0", out_tar, out_tnew, out_exc); end
    checks++; if (xalu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", xalu_busy); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    logic [31:0] s0;
    do_reset();
    issue(0, 4'hF, 0, 4'hF, 5'd8, 4'd3, 0, 2'b00, 0, 32'h8C08_0000, 32'h100);
    settle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_first_ready got=%b want=1", in_ready); end
    tick();
    checks++; if ({out_valid, out_tar, out_tnew} !== {1'b1, 5'd8, 4'd3} || out_instr !== 32'h8C08_0000)
      begin errors++; $display("FAIL lu_out got=%b/%0d/%0d/%h want=1/8/3/8c080000", out_valid, out_tar, out_tnew, out_instr); end
    s0 = stall_cnt;
    issue(5'd8, 4'd1, 0, 4'hF, 5'd10, 4'd1, 0, 2'b00, 0, 32'h0108_5021, 32'h104);
    settle();
    while (in_ready !== 1'b1 && stalls < 20) begin tick(); stalls++; settle(); end
    checks++; if (stalls != 2) begin errors++; $display("FAIL lu_stalls got=%0d want=2", stalls); end
    tick();
    in_valid = 0;
    checks++; if (stall_cnt - s0 !== 32'd2) begin errors++; $display("FAIL lu_stall_cnt got=%0d want=2", stall_cnt - s0); end
    checks++; if (out_tar !== 5'd10 || out_pc !== 32'h104) begin errors++; $display("FAIL lu_consumer got=%0d/%h want=10/104", out_tar, out_pc); end
  endtask

  task automatic test_branch();
    int stalls = 0;
    do_reset();
    issue(0, 4'hF, 0, 4'hF, 5'd9, 4'd2, 0, 2'b00, 0, 32'h3409_0001, 32'h200);
    tick();
    issue(5'd9, 4'd0, 0, 4'hF, 5'd0, 4'd0, 0, 2'b00, 0, 32'h1120_0004, 32'h204);
    settle();
    while (in_ready !== 1'b1 && stalls < 20) begin tick(); stalls++; settle(); end
    checks++; if (stalls != 2) begin errors++; $display("FAIL br_stalls got=%0d want=2", stalls); end
    tick();
    in_valid = 0;
    checks++; if (out_pc !== 32'h204 || out_tar !== 5'd0) begin errors++; $display("FAIL br_out got=%h/%0d want=204/0", out_pc, out_tar); end
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    int bad = 0;
    do_reset();
    issue(0, 4'hF, 0, 4'hF, 5'd8, 4'd3, 0, 2'b00, 0, 32'h8C08_0000, 32'h300);
    tick();
    out_ready = 0;
    issue(5'd1, 4'd0, 0, 4'hF, 5'd4, 4'd1, 0, 2'b00, 0, 32'h2024_0001, 32'h304);
    for (int k = 0; k < 5; k++) begin
      settle();
      if (in_ready !== 1'b0 || {out_valid, out_tar, out_tnew} !== {1'b1, 5'd8, 4'd3} || out_pc !== 32'h300) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles want=0", bad); end
    out_ready = 1;
    issue(5'd8, 4'd0, 0, 4'hF, 5'd6, 4'd1, 0, 2'b00, 0, 32'h0100_3021, 32'h308);
    settle();
    while (in_ready !== 1'b1 && stalls < 20) begin tick(); stalls++; settle(); end
    checks++; if (stalls != 3) begin errors++; $display("FAIL bp_cnt_frozen got=%0d stalls want=3", stalls); end
    tick();
    in_valid = 0;
  endtask

  task automatic test_xalu();
    int stalls = 0;
    do_reset();
    issue(5'd2, 4'd1, 5'd3, 4'd1, 0, 4'd0, 1, 2'b10, 0, 32'h0043_001A, 32'h400);
    tick();
    settle();
    checks++; if (xalu_busy !== 1'b1) begin errors++; $display("FAIL xalu_busy_set got=%b want=1", xalu_busy); end
    issue(0, 4'hF, 0, 4'hF, 5'd2, 4'd1, 1, 2'b00, 0, 32'h0000_1012, 32'h404);
    settle();
    while (in_ready !== 1'b1 && stalls < 30) begin tick(); stalls++; settle(); end
    checks++; if (stalls != 10) begin errors++; $display("FAIL xalu_stalls got=%0d want=10", stalls); end
    checks++; if (xalu_busy !== 1'b0) begin errors++; $display("FAIL xalu_busy_fall got=%b want=0", xalu_busy); end
    tick();
    in_valid = 0;
    checks++; if (out_tar !== 5'd2 || out_pc !== 32'h404) begin errors++; $display("FAIL xalu_fire got=%0d/%h want=2/404", out_tar, out_pc); end
  endtask

  task automatic test_ri();
    do_reset();
    issue(0, 4'hF, 0, 4'hF, 5'd3, 4'd2, 0, 2'b00, 1, 32'hFC00_0000, 32'h500);
    tick();
    checks++; if (out_instr !== 32'd0 || out_exc !== 5'd10) begin errors++; $display("FAIL ri_out got=%h/%0d want=0/10", out_instr, out_exc); end
    checks++; if ({out_valid, out_tar, out_tnew} !== {1'b1, 5'd0, 4'd0} || out_pc !== 32'h500)
      begin errors++; $display("FAIL ri_fields got=%b/%0d/%0d/%h want=1/0/0/500", out_valid, out_tar, out_tnew, out_pc); end
    issue(5'd3, 4'd0, 0, 4'hF, 5'd5, 4'd1, 0, 2'b00, 0, 32'h0060_2821, 32'h504);
    settle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ri_no_sb_write got=%b want=1", in_ready); end
    tick();
    in_valid = 0;
  endtask

  task automatic test_flush();
    logic [31:0] s0;
    do_reset();
    issue(0, 4'hF, 0, 4'hF, 5'd8, 4'd3, 0, 2'b00, 0, 32'h8C08_0000, 32'h600);
    tick();
    issue(5'd8, 4'd0, 0, 4'hF, 5'd5, 4'd1, 0, 2'b00, 0, 32'h0100_2821, 32'h604);
    settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_pre_stall got=%b want=0", in_ready); end
    tick();
    flush = 1;
    settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready_during got=%b want=0", in_ready); end
    s0 = stall_cnt;
    tick();
    flush = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got=%b want=0", out_valid); end
    checks++; if (stall_cnt !== s0) begin errors++; $display("FAIL fl_stall_cnt got=%0d want=%0d", stall_cnt, s0); end
    settle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_consumer_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_tar !== 5'd5) begin errors++; $display("FAIL fl_consumer_fire got=%b/%0d want=1/5", out_valid, out_tar); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs     = 5'($urandom_range(0, 7));
      in_rt     = 5'($urandom_range(0, 7));
      in_rsuse  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      in_rtuse  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      in_tar    = 5'($urandom_range(0, 7));
      in_tnew   = 4'($urandom_range(0, 4));
      in_xalu   = ($urandom_range(0, 7) == 0);
      in_xstart = (in_xalu && $urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 2)) : 2'b00;
      in_ri     = ($urandom_range(0, 15) == 0);
      in_instr  = $urandom;
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 199) != 0);
      settle();
      if (reset) begin
        checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, in_ready, m_ready()); end
      end
      checks++;
      if ({out_valid, out_tar, out_tnew, out_exc, xalu_busy} !== {m_ov, 5'(m_tar), 4'(m_tnew), 5'(m_exc), (m_busy > 0)})
        begin errors++; $display("FAIL rnd_out cyc=%0d got=%b/%0d/%0d/%0d/%b want=%b/%0d/%0d/%0d/%b", c,
          out_valid, out_tar, out_tnew, out_exc, xalu_busy, m_ov, m_tar, m_tnew, m_exc, (m_busy > 0)); end
      checks++;
      if (out_instr !== m_instr || out_pc !== m_pc)
        begin errors++; $display("FAIL rnd_instr_pc cyc=%0d got=%h/%h want=%h/%h", c, out_instr, out_pc, m_instr, m_pc); end
      checks++;
      if (stall_cnt !== m_stall[31:0])
        begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d want=%0d", c, stall_cnt, m_stall); end
      tick();
    end
    reset = 1; flush = 0; in_valid = 0;
  endtask

  initial begin
    reset = 0; flush = 0; out_ready = 1; in_valid = 0;
    issue(0, 4'hF, 0, 4'hF, 0, 0, 0, 2'b00, 0, 0, 0);
    in_valid = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_backpressure();
    test_xalu();
    test_ri();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
